// File: rtl/rr_stream_mux_if.sv
// Stream-mux handshake bundle: N_CH producer channels in, one consumer channel out.
// The mux connects through the slave modport; producers/consumer use master.
interface rr_stream_mux_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [N_CH*WIDTH-1:0]   in_data;
    logic [N_CH-1:0]         in_valid;
    logic [N_CH-1:0]         in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_ch;

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with external-select or round-robin
// arbitration and a one-deep registered output stage.
module rr_stream_mux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    rr_stream_mux_if.slave bus
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

    logic             can_load;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    // Grant: external select, or first requester after the last round-robin winner.
    always_comb begin
        int idx;
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (!bus.mode) begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            // Scan farthest-first so the nearest requester after rr_ptr wins.
            for (int k = N_CH; k >= 1; k--) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end
                if (bus.in_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign can_load = !out_valid_q || bus.out_ready;
    assign xfer     = gnt_vld && can_load && !rst;

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            if (bus.mode) begin
                rr_ptr_d = gnt_idx;
            end
        end else if (bus.out_ready) begin
            // Drained with nothing to reload: data and channel stay stale.
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SEL_W'(N_CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: select mode, round-robin order, backpressure,
// mode switching while stalled, and asynchronous reset mid-stream.
module tb_rr_stream_mux;

    logic clk;
    logic rst;
    logic [7:0] d [4];
    int total = 0;
    int bad   = 0;

    rr_stream_mux_if #(.N_CH(4), .WIDTH(8), .SEL_W(2)) bus ();

    rr_stream_mux #(.N_CH(4), .WIDTH(8), .SEL_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.in_data = {d[3], d[2], d[1], d[0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] dat, input logic [1:0] ch);
        check({tag, ".valid"}, {31'b0, bus.out_valid}, {31'b0, v});
        check({tag, ".data"},  {24'b0, bus.out_data},  {24'b0, dat});
        check({tag, ".ch"},    {30'b0, bus.out_ch},    {30'b0, ch});
    endtask

    task automatic check_rdy(input string tag, input logic [3:0] exp);
        check({tag, ".in_ready"}, {28'b0, bus.in_ready}, {28'b0, exp});
    endtask

    initial begin
        rst           = 1'b1;
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.in_valid  = 4'b1111;
        bus.out_ready = 1'b1;
        d[0] = 8'h10; d[1] = 8'h11; d[2] = 8'h12; d[3] = 8'h13;

        // Reset state, with requesters active
        tick(); tick();
        check_out("reset", 1'b0, 8'h00, 2'd0);
        check_rdy("reset", 4'b0000);
        rst = 1'b0;

        // Select mode: sel=2 grants ch2, then sel=1 with ch1 idle grants nothing
        bus.mode     = 1'b0;
        bus.sel      = 2'd2;
        bus.in_valid = 4'b0100;
        d[2]         = 8'hA5;
        #1;
        check_rdy("sel2", 4'b0100);
        tick();
        check_out("sel2_out", 1'b1, 8'hA5, 2'd2);
        bus.sel = 2'd1;
        #1;
        check_rdy("sel1_idle", 4'b0000);
        tick();
        check_out("sel1_drain", 1'b0, 8'hA5, 2'd2);

        // Round-robin, all valid: 0,1,2,3,0,1 back to back
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1111;
        d[0] = 8'h10; d[1] = 8'h11; d[2] = 8'h12; d[3] = 8'h13;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_rdy("rr_all", 4'b0001 << (k % 4));
            tick();
            check_out("rr_all_out", 1'b1, 8'h10 + 8'(k % 4), 2'(k % 4));
        end

        // Round-robin with ch1/ch3: 3,1 then ch0 joins -> 3,0,1
        bus.in_valid = 4'b1010;
        #1; check_rdy("rr13_a", 4'b1000);
        tick(); check_out("rr13_a_out", 1'b1, 8'h13, 2'd3);
        check_rdy("rr13_b", 4'b0010);
        tick(); check_out("rr13_b_out", 1'b1, 8'h11, 2'd1);
        bus.in_valid = 4'b1011;
        #1; check_rdy("rr013_a", 4'b1000);
        tick(); check_out("rr013_a_out", 1'b1, 8'h13, 2'd3);
        check_rdy("rr013_b", 4'b0001);
        tick(); check_out("rr013_b_out", 1'b1, 8'h10, 2'd0);
        check_rdy("rr013_c", 4'b0010);
        tick(); check_out("rr013_c_out", 1'b1, 8'h11, 2'd1);

        // Idle drain: no requesters, out_valid falls, data/ch stay stale
        bus.in_valid = 4'b0000;
        #1; check_rdy("idle", 4'b0000);
        tick(); check_out("idle_out", 1'b0, 8'h11, 2'd1);

        // Backpressure: load B7 from ch2 (rr_ptr=1), then stall 3 cycles
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0100;
        d[2]          = 8'hB7;
        #1; check_rdy("bp_load", 4'b0100);
        tick(); check_out("bp_load_out", 1'b1, 8'hB7, 2'd2);
        d[2]         = 8'hC8;
        d[0]         = 8'h50;
        bus.in_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            #1; check_rdy("bp_stall", 4'b0000);
            tick(); check_out("bp_stall_out", 1'b1, 8'hB7, 2'd2);
        end

        // Switch to select mode while stalled; held word must not change
        bus.mode = 1'b0;
        bus.sel  = 2'd0;
        #1; check_rdy("sw_stall", 4'b0000);
        tick(); check_out("sw_stall_out", 1'b1, 8'hB7, 2'd2);
        bus.out_ready = 1'b1;
        #1; check_rdy("sw_sel0", 4'b0001);
        tick(); check_out("sw_sel0_out", 1'b1, 8'h50, 2'd0);
        bus.sel = 2'd3;
        #1; check_rdy("sw_sel3_idle", 4'b0000);
        tick(); check_out("sw_sel3_out", 1'b0, 8'h50, 2'd0);

        // Back to round-robin: rr_ptr still 2 from the ch2 grant, so ch3 is next
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1111;
        d[3]         = 8'hD3;
        #1; check_rdy("rr_resume", 4'b1000);
        tick(); check_out("rr_resume_out", 1'b1, 8'hD3, 2'd3);
        check_rdy("rr_resume_next", 4'b0001);
        tick(); check_out("rr_resume_next_out", 1'b1, 8'h50, 2'd0);

        // Asynchronous reset mid-stream: immediate clear, then ch0 priority again
        #2 rst = 1'b1;
        #1;
        check_out("mid_rst", 1'b0, 8'h00, 2'd0);
        check_rdy("mid_rst", 4'b0000);
        rst = 1'b0;
        #1; check_rdy("post_rst", 4'b0001);
        tick(); check_out("post_rst_out", 1'b1, 8'h50, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
